// File: rtl/spm_arbiter_if.sv
// spm_arbiter_if: requester, response and ScratchPadMem signals of the two-port scratchpad arbiter.
// Optional rsp*_err signals exist only when SPM_ARB_ALIGN_CHECK_EN is defined.
interface spm_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [3:0]        req0_be;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [3:0]        req1_be;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
`ifdef SPM_ARB_ALIGN_CHECK_EN
    logic              rsp0_err, rsp1_err;
`endif
    logic [ADDR_W-1:0] mem_rdAddress, mem_wrAddress;
    logic [DATA_W-1:0] mem_rdData, mem_wrData;
    logic [3:0]        mem_wrEnable;

    modport slave (
`ifdef SPM_ARB_ALIGN_CHECK_EN
        output rsp0_err, rsp1_err,
`endif
        input  req0_valid, req0_we, req0_addr, req0_be, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_be, req1_wdata, mem_rdData,
        output req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata,
        output mem_rdAddress, mem_wrAddress, mem_wrData, mem_wrEnable
    );
    modport master (
`ifdef SPM_ARB_ALIGN_CHECK_EN
        input  rsp0_err, rsp1_err,
`endif
        output req0_valid, req0_we, req0_addr, req0_be, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_be, req1_wdata, mem_rdData,
        input  req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_rdAddress, mem_wrAddress, mem_wrData, mem_wrEnable
    );
endinterface

// File: rtl/spm_arbiter.sv
// spm_arbiter: two-port arbiter for the single-port ScratchPadMem with a port-1 starvation limit.
// Define SPM_ARB_ALIGN_CHECK_EN to reject misaligned transfers with an error response.
module spm_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic         clock,
    input logic         reset,
    spm_arbiter_if.slave bus
);
    logic [3:0]        wait_cnt;
    logic              starve, g0, g1, we, rd, wr, mis;
    logic [ADDR_W-1:0] addr, rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wdata, wr_data_q, rdata;
    logic [3:0]        be;
    logic              rsp_pend, rsp_owner, rsp_rd, rsp_err;

    always_comb begin
        starve = wait_cnt == 4'(MAX_WAIT);
        // Gating with reset keeps every combinational output at 0 while reset is held.
        g0 = reset & bus.req0_valid & ~(bus.req1_valid & starve);
        g1 = reset & bus.req1_valid & (~bus.req0_valid | starve);
        addr = g1 ? bus.req1_addr : bus.req0_addr;
        we = g1 ? bus.req1_we : bus.req0_we;
        be = g1 ? bus.req1_be : bus.req0_be;
        wdata = g1 ? bus.req1_wdata : bus.req0_wdata;
`ifdef SPM_ARB_ALIGN_CHECK_EN
        mis = addr[1:0] != 2'b00;
`else
        mis = 1'b0;
`endif
        rd = (g0 | g1) & ~we;
        wr = (g0 | g1) & we;
        bus.req0_ready = g0;
        bus.req1_ready = g1;
        bus.mem_rdAddress = rd ? addr : rd_addr_q;
        bus.mem_wrAddress = wr ? addr : wr_addr_q;
        bus.mem_wrData = wr ? wdata : wr_data_q;
        bus.mem_wrEnable = (wr & ~mis) ? be : 4'b0000;
        rdata = (rsp_rd & ~rsp_err) ? bus.mem_rdData : '0;
        bus.rsp0_valid = rsp_pend & ~rsp_owner;
        bus.rsp1_valid = rsp_pend & rsp_owner;
        bus.rsp0_rdata = bus.rsp0_valid ? rdata : '0;
        bus.rsp1_rdata = bus.rsp1_valid ? rdata : '0;
`ifdef SPM_ARB_ALIGN_CHECK_EN
        bus.rsp0_err = bus.rsp0_valid & rsp_err;
        bus.rsp1_err = bus.rsp1_valid & rsp_err;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rsp_pend <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_rd <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            wait_cnt <= (bus.req1_valid & ~g1) ? (starve ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
            if (rd) rd_addr_q <= addr;
            if (wr) begin
                wr_addr_q <= addr;
                wr_data_q <= wdata;
            end
            rsp_pend <= g0 | g1;
            rsp_owner <= g1;
            rsp_rd <= ~we;
            rsp_err <= mis;
        end
    end
endmodule

// File: tb/tb_spm_arbiter.sv
// tb_spm_arbiter: directed stimulus with a response scoreboard drained by an independent monitor.
// Models the ScratchPadMem (sync read, byte-lane writes) behind the arbiter.
module tb_spm_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spm_arbiter_if bus ();
    spm_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct packed {logic port; logic [31:0] data; logic err;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    logic [31:0] mem [0:63];

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++)
            if (bus.mem_wrEnable[i]) mem[bus.mem_wrAddress[7:2]][8*i +: 8] <= bus.mem_wrData[8*i +: 8];
        bus.mem_rdData <= mem[bus.mem_rdAddress[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus.rsp0_valid && bus.rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
        else if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (sb.size() == 0) chk("rsp_unexpected_port1", {31'd0, bus.rsp1_valid}, 32'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                chk("rsp_port", {31'd0, bus.rsp1_valid}, {31'd0, e.port});
                chk("rsp_rdata", bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata, e.data);
`ifdef SPM_ARB_ALIGN_CHECK_EN
                chk("rsp_err", {31'd0, bus.rsp1_valid ? bus.rsp1_err : bus.rsp0_err}, {31'd0, e.err});
`endif
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_we = w; bus.req0_be = b; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_we = w; bus.req1_be = b; bus.req1_wdata = d;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic both_cycle(input logic exp_g1, input logic push);
        drive(0, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0);
        drive(1, 1'b1, 32'h20, 1'b0, 4'd0, 32'd0);
        if (push) sb.push_back('{exp_g1, exp_g1 ? 32'h11BB33DD : 32'hDEADBEEF, 1'b0});
        @(negedge clock);
        chk("starve_ready0", {31'd0, bus.req0_ready}, {31'd0, ~exp_g1});
        chk("starve_ready1", {31'd0, bus.req1_ready}, {31'd0, exp_g1});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[32'h10 >> 2] = 32'hDEADBEEF;
        mem[32'h20 >> 2] = 32'h11223344;
        idle();
        drive(0, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("reset_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("reset_wren", {28'd0, bus.mem_wrEnable}, 32'd0);
        chk("reset_rdaddr", bus.mem_rdAddress, 32'd0);
        chk("reset_wrdata", bus.mem_wrData, 32'd0);
        idle();
        reset = 1'b1;
        next();
        drive(0, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0);
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        @(negedge clock);
        chk("rd_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("rd_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rd_addr", bus.mem_rdAddress, 32'h10);
        chk("rd_wren", {28'd0, bus.mem_wrEnable}, 32'd0);
        next();
        idle();
        next();
        drive(1, 1'b1, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
        sb.push_back('{1'b1, 32'd0, 1'b0});
        @(negedge clock);
        chk("bw_ready1", {31'd0, bus.req1_ready}, 32'd1);
        chk("bw_wren", {28'd0, bus.mem_wrEnable}, 32'b0101);
        chk("bw_wraddr", bus.mem_wrAddress, 32'h20);
        chk("bw_wrdata", bus.mem_wrData, 32'hAABBCCDD);
        next();
        drive(1, 1'b1, 32'h20, 1'b0, 4'd0, 32'd0);
        sb.push_back('{1'b1, 32'h11BB33DD, 1'b0});
        next();
        idle();
        drive(0, 1'b1, 32'h40, 1'b1, 4'hF, 32'h5);
        sb.push_back('{1'b0, 32'd0, 1'b0});
        next();
        drive(0, 1'b1, 32'h40, 1'b0, 4'd0, 32'd0);
        sb.push_back('{1'b0, 32'h5, 1'b0});
        next();
        drive(0, 1'b1, 32'h10, 1'b1, 4'd0, 32'hFFFFFFFF);
        sb.push_back('{1'b0, 32'd0, 1'b0});
        @(negedge clock);
        chk("be0_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("be0_wren", {28'd0, bus.mem_wrEnable}, 32'd0);
        next();
        drive(0, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0);
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        next();
        idle();
        next();
        for (int i = 0; i < 10; i++) begin
            both_cycle(i == 4 || i == 9, 1'b1);
            next();
        end
        idle();
        next();
        both_cycle(1'b0, 1'b1);
        next();
        both_cycle(1'b0, 1'b1);
        next();
        both_cycle(1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_mid_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_mid_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        chk("rst_mid_rdaddr", bus.mem_rdAddress, 32'd0);
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) next();
        for (int i = 0; i < 5; i++) begin
            both_cycle(i == 4, 1'b1);
            next();
        end
        idle();
`ifdef SPM_ARB_ALIGN_CHECK_EN
        next();
        drive(1, 1'b1, 32'h13, 1'b1, 4'hF, 32'hFFFFFFFF);
        sb.push_back('{1'b1, 32'd0, 1'b1});
        @(negedge clock);
        chk("mis_ready1", {31'd0, bus.req1_ready}, 32'd1);
        chk("mis_wren", {28'd0, bus.mem_wrEnable}, 32'd0);
        next();
        drive(1, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0);
        sb.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
        next();
        idle();
`endif
        for (int i = 0; i < 20 && sb.size() != 0; i++) next();
        repeat (2) next();
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spm_arbiter.md
Name: spm_arbiter

Overview:
- Two-requester arbiter in front of the single-port ScratchPadMem (word data, 4 byte write enables, synchronous read).
- Port 0 is the core data path; port 1 is the boot/DMA loader that fills or drains the scratchpad.
- Grants at most one access per cycle and applies a starvation limit on port 1.
- Routes the one-cycle-late read data, or write acknowledge, back to the owning requester.

Parameters:
- ADDR_W, 32, byte address width on requester and memory side.
- DATA_W, 32, data width; fixed at 4 byte lanes.
- MAX_WAIT, 4, consecutive cycles port 1 may be held off before it is force-granted (range 1..15).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_addr  in  ADDR_W  byte address.
- req0_we  in  1  1 = write, 0 = read.
- req0_be  in  4  byte enables, used for writes.
- req0_wdata  in  DATA_W  write data.
- rsp0_valid  out  1  port 0 response.
- rsp0_rdata  out  DATA_W  read data; 0 for write acks.
- req1_* / rsp1_*  same set as port 0, for port 1.
- mem_rdAddress  out  ADDR_W  to ScratchPadMem rdAddress.
- mem_rdData  in  DATA_W  from ScratchPadMem, valid the cycle after address.
- mem_wrAddress  out  ADDR_W  to wrAddress.
- mem_wrData  out  DATA_W  to wrData.
- mem_wrEnable  out  4  byte write strobes, bit i = byte lane i.

Behaviour:
- Reset (reset low, asynchronous) clears:
  - all ready and rsp_valid outputs to 0;
  - mem_wrEnable to 0, mem addresses and mem_wrData to 0;
  - wait counter to 0, response-pending flag to 0.
- Grant is combinational from current valids:
  - only req0 valid -> grant 0;
  - only req1 valid -> grant 1;
  - both valid -> grant 0, unless wait_cnt == MAX_WAIT, then grant 1.
- reqN_ready = grantN. A transfer occurs on valid & ready; no ready without valid.
- Wait counter:
  - increments (saturating at MAX_WAIT) each cycle req1_valid is high and not granted;
  - clears on a port 1 grant or when req1_valid is low.
- Granted read: mem_rdAddress = addr; mem_wrEnable = 0.
- Granted write: mem_wrAddress = addr, mem_wrData = wdata, mem_wrEnable = be.
  - Write with be = 0 is accepted and acknowledged but changes nothing.
- No grant: mem_wrEnable = 0; addresses hold last value (don't-care to memory).
- Response register captures owner port and op type on each transfer.
- Next cycle, rsp{owner}_valid = 1 for exactly one cycle:
  - rdata = mem_rdData for reads, 0 for writes.
  - Latency: 1 cycle, fully pipelined; back-to-back transfers give back-to-back responses.
- Write at cycle N followed by a read of the same address at N+1 returns the new data at N+2.
- Reset mid-access: the pending response is dropped; no rsp_valid after reset release until a new transfer.
- Address passes through unchanged; the memory ignores addr[1:0].

Optional Feature:
- SPM_ARB_ALIGN_CHECK_EN, when defined:
  - adds outputs rsp0_err and rsp1_err (1 bit each).
  - A transfer with addr[1:0] != 0 is accepted, but mem_wrEnable is forced to 0 for it.
  - Its response has err = 1 and rdata = 0. Aligned responses have err = 0.
- Undefined: the err ports are absent and misaligned addresses go to memory unchanged.

Test Plan:
- Single read: memory preloaded with 0xDEADBEEF at address 0x10; req0 read 0x10 -> req0_ready same cycle; rsp0_valid and rsp0_rdata = 0xDEADBEEF one cycle later; rsp1_valid stays 0.
- Byte-lane write: word 0x20 = 0x11223344; req1 write wdata 0xAABBCCDD, be = 0b0101 -> mem_wrEnable = 0101; a later read of 0x20 returns 0x11BB33DD.
- Starvation: req0 and req1 both held valid continuously, MAX_WAIT = 4 -> grant pattern 0,0,0,0,1,0,0,0,0,1; no cycle has both readys high.
- Back-to-back: req0 write 0x40 = 0x5 at cycle N, req0 read 0x40 at N+1 -> rsp0 write ack at N+1 (rdata 0), rsp0 rdata = 0x5 at N+2.
- Reset mid-operation: read accepted at cycle N, reset asserted low before the N+1 edge -> all outputs 0 immediately; no rsp_valid after release; wait counter restarts from 0.
- Align check (macro defined): req1 write to 0x13 -> mem_wrEnable stays 0; rsp1_err = 1 next cycle; memory unchanged.
